// File: rtl/scale_coord_gen_pkg.sv
// Shared constants and types for the scaler coordinate path.
// The configuration stage uses the same scale and count widths.
package scale_coord_gen_pkg;
  localparam int FRAC_BITS = 11;
  localparam int SCALE_ONE = 1 << FRAC_BITS;
  localparam int SCALE_W   = 15;
  localparam int CNT_W     = 11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/scale_coord_gen_scale_axis_acc.sv
// Per-axis output counter plus source-coordinate accumulator.
// The integer part is clamped to the source extent, and the fraction is zeroed when clamped.
module scale_axis_acc #(
  parameter int FRAC_BITS = scale_coord_gen_pkg::FRAC_BITS,
  parameter int SRC_NUM   = 1280,
  parameter int COORD_W   = 12,
  parameter int ACC_W     = 26
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   clear,
  input  logic                                   step,
  input  logic                                   wrap,
  input  logic [scale_coord_gen_pkg::SCALE_W-1:0] scale,
  input  logic [scale_coord_gen_pkg::CNT_W-1:0]   num,
  output logic                                   first,
  output logic                                   last,
  output logic [COORD_W-1:0]                     coord,
  output logic [FRAC_BITS-1:0]                   frac
);
  import scale_coord_gen_pkg::*;

  localparam int IW = ACC_W - FRAC_BITS;
  localparam logic [IW-1:0] MAX_INT = IW'(SRC_NUM - 1);

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [IW-1:0]    int_part;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear || wrap) begin
      cnt <= '0;
      acc <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc + ACC_W'(scale);
    end
  end

  assign int_part = acc[ACC_W-1:FRAC_BITS];
  assign first    = (cnt == '0);
  assign last     = (cnt == num - CNT_W'(1));

  always_comb begin
    coord = int_part[COORD_W-1:0];
    frac  = acc[FRAC_BITS-1:0];
    if (int_part > MAX_INT) begin
      coord = COORD_W'(SRC_NUM - 1);
      frac  = '0;
    end
  end
endmodule

// File: rtl/scale_coord_gen.sv
// Walks the output raster and emits one clamped source coordinate per output pixel.
// Handshake: a beat transfers on a clock edge where coord_valid && coord_ready; valid holds with stable outputs until then.
module scale_coord_gen #(
  parameter int FRAC_BITS = scale_coord_gen_pkg::FRAC_BITS,
  parameter int SRC_H_NUM = 1280,
  parameter int SRC_V_NUM = 720,
  parameter int COORD_W   = 12,
  parameter int ACC_W     = 26
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [14:0]          x_scale,
  input  logic [14:0]          y_scale,
  input  logic [10:0]          target_h_num,
  input  logic [10:0]          target_v_num,
  output logic                 coord_valid,
  input  logic                 coord_ready,
  output logic [COORD_W-1:0]   src_x,
  output logic [FRAC_BITS-1:0] x_frac,
  output logic [COORD_W-1:0]   src_y,
  output logic [FRAC_BITS-1:0] y_frac,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 frame_done
);
  import scale_coord_gen_pkg::*;

  state_t             state;
  logic [SCALE_W-1:0] x_scale_q, y_scale_q;
  logic [CNT_W-1:0]   h_num_q, v_num_q;
  logic               accept, xfer, at_eol, at_eof, clr;
  logic               x_first, x_last, y_first, y_last;

  assign accept = (state == IDLE) && start && (target_h_num != '0) && (target_v_num != '0);
  assign xfer   = coord_valid && coord_ready;
  assign at_eol = x_last;
  assign at_eof = x_last && y_last;
  // Clearing again after the last beat returns the coordinate outputs to zero while idle.
  assign clr    = accept || (xfer && at_eof);

  assign sof = coord_valid && x_first && y_first;
  assign eol = coord_valid && at_eol;
  assign eof = coord_valid && at_eof;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_scale_q <= '0;
      y_scale_q <= '0;
      h_num_q   <= '0;
      v_num_q   <= '0;
    end else if (accept) begin
      x_scale_q <= x_scale;
      y_scale_q <= y_scale;
      h_num_q   <= target_h_num;
      v_num_q   <= target_v_num;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      coord_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state       <= RUN;
          busy        <= 1'b1;
          coord_valid <= 1'b1;
        end
        RUN: if (xfer && at_eof) begin
          state       <= IDLE;
          busy        <= 1'b0;
          coord_valid <= 1'b0;
          frame_done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  scale_axis_acc #(
    .FRAC_BITS(FRAC_BITS), .SRC_NUM(SRC_H_NUM), .COORD_W(COORD_W), .ACC_W(ACC_W)
  ) u_x (
    .clk(clk), .rstn(rstn), .clear(clr),
    .step(xfer && !at_eol), .wrap(xfer && at_eol && !at_eof),
    .scale(x_scale_q), .num(h_num_q),
    .first(x_first), .last(x_last), .coord(src_x), .frac(x_frac)
  );

  scale_axis_acc #(
    .FRAC_BITS(FRAC_BITS), .SRC_NUM(SRC_V_NUM), .COORD_W(COORD_W), .ACC_W(ACC_W)
  ) u_y (
    .clk(clk), .rstn(rstn), .clear(clr),
    .step(xfer && at_eol && !at_eof), .wrap(1'b0),
    .scale(y_scale_q), .num(v_num_q),
    .first(y_first), .last(y_last), .coord(src_y), .frac(y_frac)
  );
endmodule

// File: tb/tb_scale_coord_gen.sv
// Bench for scale_coord_gen: table-driven frames, random frames with backpressure,
// and hand sequences for ignored starts, config changes and mid-frame reset.
module tb_scale_coord_gen;
  localparam int SRC_H = 1280;
  localparam int SRC_V = 720;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [14:0] x_scale = '0;
  logic [14:0] y_scale = '0;
  logic [10:0] target_h_num = '0;
  logic [10:0] target_v_num = '0;
  logic        coord_ready = 1'b0;
  logic        coord_valid, sof, eol, eof, busy, frame_done;
  logic [11:0] src_x, src_y;
  logic [10:0] x_frac, y_frac;

  int n_pass = 0;
  int n_total = 0;
  logic [48:0] exp_q[$];

  typedef struct {
    int xs; int ys; int h; int v; int duty;
    int beats; int lx; int lxf; int ly; int lyf;
  } vec_t;
  vec_t vecs[6];

  scale_coord_gen dut (
    .clk(clk), .rstn(rstn), .start(start), .x_scale(x_scale), .y_scale(y_scale),
    .target_h_num(target_h_num), .target_v_num(target_v_num),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .src_x(src_x), .x_frac(x_frac), .src_y(src_y), .y_frac(y_frac),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [48:0] pack(input int sx, input int xf, input int sy, input int yf,
                                       input logic s, input logic e, input logic f);
    return {12'(sx), 11'(xf), 12'(sy), 11'(yf), s, e, f};
  endfunction

  function automatic logic [48:0] obs();
    return {src_x, x_frac, src_y, y_frac, sof, eol, eof};
  endfunction

  // Reference: each output pixel maps to index*scale, clamped to the source extent.
  task automatic push_frame(input int xs, input int ys, input int h, input int v);
    longint ax, ay;
    int sx, xf, sy, yf;
    for (int y = 0; y < v; y++) begin
      ay = longint'(y) * ys;
      sy = int'(ay >> 11); yf = int'(ay % 2048);
      if (sy > SRC_V - 1) begin sy = SRC_V - 1; yf = 0; end
      for (int x = 0; x < h; x++) begin
        ax = longint'(x) * xs;
        sx = int'(ax >> 11); xf = int'(ax % 2048);
        if (sx > SRC_H - 1) begin sx = SRC_H - 1; xf = 0; end
        exp_q.push_back(pack(sx, xf, sy, yf, (x == 0 && y == 0), (x == h - 1),
                             (x == h - 1 && y == v - 1)));
      end
    end
  endtask

  task automatic run_frame(input int xs, input int ys, input int h, input int v, input int duty,
                           input int chg_h, output int beats, output logic [48:0] last);
    int budget;
    logic [48:0] held, expv;
    logic stalled, done;
    push_frame(xs, ys, h, v);
    @(negedge clk);
    x_scale = 15'(xs); y_scale = 15'(ys);
    target_h_num = 11'(h); target_v_num = 11'(v);
    start = 1'b1; coord_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_latency_valid", coord_valid, 1);
    check("start_latency_busy", busy, 1);
    beats = 0; stalled = 1'b0; done = 1'b0; last = '0; held = '0;
    budget = h * v * 20 + 100;
    while (!done && budget > 0) begin
      budget--;
      if (stalled) begin
        check("stall_valid_held", coord_valid, 1);
        check("stall_outputs_held", obs(), held);
      end
      coord_ready = ($urandom_range(1, 100) <= duty);
      start = ($urandom_range(0, 7) == 0);
      if (beats == 5 && chg_h != 0) target_h_num = 11'(chg_h);
      if (coord_valid && coord_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          check("beat", obs(), expv);
        end
        last = obs(); beats++; stalled = 1'b0;
        if (eof) begin done = 1'b1; start = 1'b1; end
      end else begin
        stalled = coord_valid; held = obs();
      end
      @(negedge clk);
    end
    start = 1'b0; coord_ready = 1'b0;
    check("frame_timeout", done, 1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check("frame_done_pulse", frame_done, 1);
    check("valid_after_eof", coord_valid, 0);
    check("busy_after_eof", busy, 0);
    @(negedge clk);
    check("frame_done_width", frame_done, 0);
    check("no_restart_on_eof_start", busy, 0);
  endtask

  initial begin
    int beats;
    logic [48:0] last;
    logic seen;

    vecs[0] = '{2048, 2048, 4, 2, 100, 8, 3, 0, 1, 0};
    vecs[1] = '{1024, 2048, 4, 1, 100, 4, 1, 1024, 0, 0};
    vecs[2] = '{4096, 2048, 640, 1, 100, 640, 1278, 0, 0, 0};
    vecs[3] = '{8192, 2048, 640, 1, 100, 640, 1279, 0, 0, 0};
    vecs[4] = '{3000, 1500, 37, 5, 30, 185, 52, 1504, 2, 1904};
    vecs[5] = '{2048, 32767, 2, 50, 70, 100, 1, 0, 719, 0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {coord_valid, src_x, x_frac, src_y, y_frac, sof, eol, eof, busy, frame_done}, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {coord_valid, busy, frame_done}, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].xs, vecs[i].ys, vecs[i].h, vecs[i].v, vecs[i].duty, 0, beats, last);
      check("vec_beats", beats, vecs[i].beats);
      check("vec_last_src_x", last[48:37], vecs[i].lx);
      check("vec_last_x_frac", last[36:26], vecs[i].lxf);
      check("vec_last_src_y", last[25:14], vecs[i].ly);
      check("vec_last_y_frac", last[13:3], vecs[i].lyf);
    end

    for (int i = 0; i < 4; i++) begin
      int rh, rv;
      rh = $urandom_range(1, 40); rv = $urandom_range(1, 6);
      run_frame($urandom_range(512, 12000), $urandom_range(512, 32767), rh, rv,
                $urandom_range(20, 100), 0, beats, last);
      check("rand_beats", beats, rh * rv);
    end

    // Config change mid-frame: the running frame keeps its latched width.
    run_frame(2048, 2048, 640, 1, 100, 645, beats, last);
    check("chg_cur_beats", beats, 640);
    run_frame(2048, 2048, 645, 1, 100, 0, beats, last);
    check("chg_next_beats", beats, 645);

    // Zero-size starts are ignored.
    @(negedge clk);
    x_scale = 15'd2048; y_scale = 15'd2048;
    target_h_num = 11'd4; target_v_num = 11'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("zero_v_busy", {busy, coord_valid}, 0);
    target_h_num = 11'd0; target_v_num = 11'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("zero_h_busy", {busy, coord_valid}, 0);

    // Reset mid-frame aborts without a frame_done.
    target_h_num = 11'd8; target_v_num = 11'd4; x_scale = 15'd3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; coord_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_frame_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_reset_outputs", {coord_valid, src_x, x_frac, src_y, y_frac, sof, eol, eof, busy, frame_done}, 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | frame_done | busy | coord_valid;
    end
    check("no_frame_done_after_reset", seen, 0);
    coord_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
